// File: rtl/panel_write_arbiter.sv
// Two-requester arbiter for the shared ledpanel control write bus.
// Burst-locked round-robin grants, released on last, beat limit or stall timeout.
module panel_write_arbiter #(
    parameter int EN_W          = 6,
    parameter int WR_W          = 4,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 24,
    parameter int MAX_BURST     = 256,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_last,
    input  logic [EN_W-1:0]   a_en,
    input  logic [WR_W-1:0]   a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdat,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_last,
    input  logic [EN_W-1:0]   b_en,
    input  logic [WR_W-1:0]   b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdat,
    output logic [EN_W-1:0]   ctrl_en,
    output logic [WR_W-1:0]   ctrl_wr,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_wdat,
    output logic [1:0]        grant,
    output logic              timeout_pulse
);

    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_A = 2'b01;
    localparam logic [1:0] GRANT_B = 2'b10;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

    logic [1:0]         state_r, state_s;
    logic               prio_b_r, prio_b_s;
    logic [BEAT_W-1:0]  beat_cnt_r, beat_cnt_s;
    logic [STALL_W-1:0] stall_cnt_r, stall_cnt_s;
    logic               timeout_s;
    logic               load_s;
    logic               release_s;
    logic               cur_valid_s;
    logic               cur_last_s;
    logic [EN_W-1:0]    sel_en_s;
    logic [WR_W-1:0]    sel_wr_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdat_s;

    assign a_ready = (state_r == GRANT_A);
    assign b_ready = (state_r == GRANT_B);
    assign grant   = state_r;

    // Route the current owner's handshake and beat fields
    always_comb begin
        if (state_r == GRANT_B) begin
            cur_valid_s = b_valid;
            cur_last_s  = b_last;
            sel_en_s    = b_en;
            sel_wr_s    = b_wr;
            sel_addr_s  = b_addr;
            sel_wdat_s  = b_wdat;
        end else begin
            cur_valid_s = a_valid;
            cur_last_s  = a_last;
            sel_en_s    = a_en;
            sel_wr_s    = a_wr;
            sel_addr_s  = a_addr;
            sel_wdat_s  = a_wdat;
        end
    end

    // Arbitration, burst accounting and release decisions
    always_comb begin
        state_s     = state_r;
        prio_b_s    = prio_b_r;
        beat_cnt_s  = beat_cnt_r;
        stall_cnt_s = stall_cnt_r;
        timeout_s   = 1'b0;
        load_s      = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_s = prio_b_r ? GRANT_B : GRANT_A;
                end else if (a_valid) begin
                    state_s = GRANT_A;
                end else if (b_valid) begin
                    state_s = GRANT_B;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_A, GRANT_B: begin
                if (cur_valid_s) begin
                    load_s      = 1'b1;
                    stall_cnt_s = {STALL_W{1'b0}};
                    if (cur_last_s || (beat_cnt_r == BEAT_LAST)) begin
                        release_s = 1'b1;
                    end else begin
                        beat_cnt_s = beat_cnt_r + BEAT_W'(1'b1);
                    end
                end else begin
                    // A beat in the final stall cycle wins, so the pulse only fires beatless.
                    if (stall_cnt_r == STALL_LAST) begin
                        release_s = 1'b1;
                        timeout_s = 1'b1;
                    end else begin
                        stall_cnt_s = stall_cnt_r + STALL_W'(1'b1);
                    end
                end
                if (release_s) begin
                    state_s     = IDLE;
                    prio_b_s    = (state_r == GRANT_A);
                    beat_cnt_s  = {BEAT_W{1'b0}};
                    stall_cnt_s = {STALL_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = IDLE;
                beat_cnt_s  = {BEAT_W{1'b0}};
                stall_cnt_s = {STALL_W{1'b0}};
            end
        endcase
    end

    // Registered arbiter state and panel control bus
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            prio_b_r      <= 1'b0;
            beat_cnt_r    <= {BEAT_W{1'b0}};
            stall_cnt_r   <= {STALL_W{1'b0}};
            timeout_pulse <= 1'b0;
            ctrl_en       <= {EN_W{1'b0}};
            ctrl_wr       <= {WR_W{1'b0}};
            ctrl_addr     <= {ADDR_W{1'b0}};
            ctrl_wdat     <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_s;
            prio_b_r      <= prio_b_s;
            beat_cnt_r    <= beat_cnt_s;
            stall_cnt_r   <= stall_cnt_s;
            timeout_pulse <= timeout_s;
            if (load_s) begin
                ctrl_en   <= sel_en_s;
                ctrl_wr   <= sel_wr_s;
                ctrl_addr <= sel_addr_s;
                ctrl_wdat <= sel_wdat_s;
            end else begin
                // Strobe is one cycle wide; the rest of the bus holds its last beat.
                ctrl_en <= {EN_W{1'b0}};
            end
        end
    end

endmodule
